// File: rtl/counter_pkg.sv
// Counter package: widths taken from the shared macros, counter type enum and code decode.
`include "defines.sv"

package counter_pkg;
    localparam int TYPE_W   = `tcTypeLen;
    localparam int PRESET_W = `tcPresetLen;
    localparam int ACC_W    = `tcAccLen;
    localparam int CMP_W    = (ACC_W > PRESET_W) ? ACC_W : PRESET_W;

    localparam logic [TYPE_W-1:0] CODE_UP   = `counterType1;
    localparam logic [TYPE_W-1:0] CODE_DOWN = `counterType2;
    localparam logic [TYPE_W-1:0] CODE_UPDN = `counterType3;

    typedef enum logic [1:0] {
        CT_IDLE = 2'd0,
        CT_UP   = 2'd1,
        CT_DOWN = 2'd2,
        CT_UPDN = 2'd3
    } ctr_type_e;

    // Any code outside the three counter types falls back to idle.
    function automatic ctr_type_e decode_type(input logic [TYPE_W-1:0] code);
        if (code == CODE_UP)   return CT_UP;
        if (code == CODE_DOWN) return CT_DOWN;
        if (code == CODE_UPDN) return CT_UPDN;
        return CT_IDLE;
    endfunction
endpackage

// File: rtl/counter_if.sv
// Control/status bundle between a counter and its host.
interface counter_if;
    import counter_pkg::*;

    logic                en;
    logic                ld;
    logic                cu;
    logic                cd;
    logic [TYPE_W-1:0]   type_sel;
    logic [PRESET_W-1:0] preset;
    logic                DN;
    logic                OV;
    logic                UN;
    logic [ACC_W-1:0]    ACC;

    modport master (
        output en, ld, cu, cd, type_sel, preset,
        input  DN, OV, UN, ACC
    );

    modport slave (
        input  en, ld, cu, cd, type_sel, preset,
        output DN, OV, UN, ACC
    );
endinterface

// File: rtl/counter_edge_detect.sv
// Registered rising-edge detector: rise is high while d is high and was low last clock.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic d_q;
    logic d_d;

    assign d_d = d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d_d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/defines.sv
// Width and type-code macros shared by the counter and timer blocks.
`ifndef TC_DEFINES_SV
`define TC_DEFINES_SV

`define tcTypeLen    2
`define tcPresetLen  8
`define tcAccLen     8

`define counterType1 2'd1
`define counterType2 2'd2
`define counterType3 2'd3

`define timerTypeTon 2'd1
`define timerTypeTof 2'd2
`define timerTypeTp  2'd3

`endif

// File: rtl/counter.sv
// Up/down/up-down event counter with preset load and done flag.
// COUNTER_OVF_SAT_EN: saturate at the limits with sticky OV/UN; otherwise wrap with OV/UN tied low.
//
// state   | meaning
// CT_IDLE | edges ignored, ACC/OV/UN held, DN low
// CT_UP   | up edges increment, DN = ACC >= preset
// CT_DOWN | down edges decrement, DN = ACC == 0
// CT_UPDN | up increments, down decrements, both cancel, DN = ACC >= preset
module counter
    import counter_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    counter_if.slave bus
);
    ctr_type_e        type_q, type_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ov_q, ov_d;
    logic             un_q, un_d;
    logic             up_e, dn_e;
    logic             inc, dec;
    logic             dn;

    edge_detect u_cu_edge (.clk(clk), .reset(reset), .d(bus.cu), .rise(up_e));
    edge_detect u_cd_edge (.clk(clk), .reset(reset), .d(bus.cd), .rise(dn_e));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q <= CT_IDLE;
            acc_q  <= '0;
            ov_q   <= 1'b0;
            un_q   <= 1'b0;
        end else begin
            type_q <= type_d;
            acc_q  <= acc_d;
            ov_q   <= ov_d;
            un_q   <= un_d;
        end
    end

    // Counting follows the type presented at this edge so the first edge after reset counts.
    always_comb begin
        type_d = decode_type(bus.type_sel);
        acc_d  = acc_q;
        ov_d   = ov_q;
        un_d   = un_q;
        inc    = 1'b0;
        dec    = 1'b0;
        unique case (type_d)
            CT_UP:   inc = up_e;
            CT_DOWN: dec = dn_e;
            CT_UPDN: begin
                inc = up_e & ~dn_e;
                dec = dn_e & ~up_e;
            end
            default: ;
        endcase

        if (bus.ld) begin
            acc_d = ACC_W'(bus.preset);
            ov_d  = 1'b0;
            un_d  = 1'b0;
        end else if (bus.en) begin
            if (inc) begin
`ifdef COUNTER_OVF_SAT_EN
                if (&acc_q) ov_d = 1'b1;
                else        acc_d = acc_q + ACC_W'(1);
`else
                acc_d = acc_q + ACC_W'(1);
`endif
            end else if (dec) begin
`ifdef COUNTER_OVF_SAT_EN
                if (acc_q == '0) un_d = 1'b1;
                else             acc_d = acc_q - ACC_W'(1);
`else
                acc_d = acc_q - ACC_W'(1);
`endif
            end
        end
    end

    always_comb begin
        dn = 1'b0;
        unique case (type_q)
            CT_UP, CT_UPDN: dn = (CMP_W'(acc_q) >= CMP_W'(bus.preset));
            CT_DOWN:        dn = (acc_q == '0);
            default:        dn = 1'b0;
        endcase
    end

    assign bus.ACC = acc_q;
    assign bus.DN  = dn;
    assign bus.OV  = ov_q;
    assign bus.UN  = un_q;
endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameters: none; widths SHALL come from the shared macros `tcTypeLen, `tcPresetLen and `tcAccLen.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  count enable; low means count edges are ignored and ACC is retained.
REQ-005 ld  input  1  synchronous load strobe: ACC <= preset.
REQ-006 cu  input  1  count-up pulse input, level signal, rising-edge counted.
REQ-007 cd  input  1  count-down pulse input, level signal, rising-edge counted.
REQ-008 type  input  `tcTypeLen  counter type select: `counterType1 up, `counterType2 down, `counterType3 up/down.
REQ-009 preset  input  `tcPresetLen  preset / compare value.
REQ-010 DN  output  1  done flag.
REQ-011 OV  output  1  sticky overflow flag.
REQ-012 UN  output  1  sticky underflow flag.
REQ-013 ACC  output  `tcAccLen  accumulated count.

Function
REQ-014 CounterType register: SHALL load the decoded type every posedge clk; an unknown type code decodes to the default type (idle).
REQ-015 Edge detection: cu_q and cd_q SHALL register cu and cd each clk; an up edge is cu & ~cu_q, a down edge is cd & ~cd_q.
REQ-016 Latency: an edge sampled at posedge k SHALL update ACC, DN, OV and UN at that same edge, visible after posedge k (one-cycle latency from input change).
REQ-017 Up type: on up edge with en, ACC+1; down edges ignored; DN = (ACC >= preset), evaluated on the new ACC.
REQ-018 Down type: on down edge with en, ACC-1; up edges ignored; DN = (ACC == 0), evaluated on the new ACC.
REQ-019 Up/down type: up edge increments, down edge decrements; simultaneous up and down edges SHALL leave ACC unchanged; DN = (ACC >= preset).
REQ-020 Default (idle) type: edges SHALL be ignored; ACC, OV and UN are held; DN = 0.
REQ-021 ld SHALL have priority over count edges in the same cycle: ACC <= preset (zero-extended or truncated to `tcAccLen), OV <= 0, UN <= 0; edges in that cycle are discarded.
REQ-022 en low SHALL discard edges, retain ACC, and keep DN evaluated on the held ACC; edge registers keep tracking, so no edge is counted when en rises.
REQ-023 A type change mid-operation SHALL retain ACC; DN is re-evaluated under the new type on the next clk.
REQ-024 Overflow/underflow behaviour at ACC all-ones (up) or ACC 0 (down) is set by REQ-027 and REQ-028.

Reset
REQ-025 Asserting reset SHALL immediately set ACC=0, DN=0, OV=0, UN=0, cu_q=0, cd_q=0, and CounterType to the default (idle) type.
REQ-026 Reset mid-count SHALL discard any pending edge; the first posedge after deassertion with cu high counts as an up edge (cu_q=0).

Configuration
REQ-027 With COUNTER_OVF_SAT_EN defined: an up count at all-ones SHALL hold ACC and set OV; a down count at 0 SHALL hold ACC and set UN; OV and UN stay set until ld or reset.
REQ-028 Without COUNTER_OVF_SAT_EN: ACC SHALL wrap modulo 2^`tcAccLen; OV and UN are tied 0.

Structure
REQ-029 Shared defines.v SHALL hold `tcTypeLen, `tcPresetLen, `tcAccLen and `counterType1..`counterType3, alongside the timer type codes.
REQ-030 A sub-module edge_detect (registered rising-edge detector with asynchronous reset) SHALL be instantiated twice, for cu and cd.

Verification
REQ-031 Up type, preset=3, en=1, 3 cu pulses -> ACC 1,2,3; DN=1 after the third edge; a 4th pulse -> ACC=4, DN=1.
REQ-032 Down type, preset=2, ld pulse, 2 cd pulses -> ACC 2,1,0; DN=1 after the second edge.
REQ-033 Up/down type, cu and cd rising in the same cycle -> ACC unchanged; ld and cu in the same cycle -> ACC=preset, no increment.
REQ-034 Up type, preset=all-ones, ld, 1 cu pulse -> with macro: ACC=all-ones, OV=1 until ld; without macro: ACC=0, OV=0.
REQ-035 cu held high for 10 cycles -> exactly one increment; en=0 during a pulse -> ACC retained, no count.
REQ-036 reset asserted between clk edges with ACC=5 -> ACC=0, DN=OV=UN=0 immediately; after release, ACC does not change until a new edge.
